// File: rtl/apb_rr_master_if.sv
// Bundles the two requester command ports, the APB bus and the response port
// of apb_rr_master. The master modport is the arbiter view and the slave modport is the environment view.
interface apb_rr_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  logic              rsp_valid;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_ready, req1_ready,
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr,
    output rsp_valid, rsp_id, rsp_rdata, rsp_err
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_ready, req1_ready,
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr,
    input  rsp_valid, rsp_id, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/apb_rr_master.sv
// Two-requester round-robin APB master with a local address-range guard and a
// pready timeout; each accepted command yields exactly one tagged response pulse.
module apb_rr_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 10,
  parameter int TIMEOUT   = 16
) (
  input  logic                  pclk,
  input  logic                  prst_n,
  apb_rr_master_if.master       bus,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_ERR    = 2'd3
  } state_e;

  localparam logic [7:0]        TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LIM  = ADDR_W'(MEM_DEPTH);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              id_q, id_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              any_req;
  logic              grant;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Handshake: a command transfers in a cycle where reqN_valid && reqN_ready.
  // Ready is combinational, only in IDLE and only for the winner; the requester
  // holds valid and payload until then and may withdraw valid beforehand.
  assign any_req   = bus.req0_valid | bus.req1_valid;
  assign grant     = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
  assign sel_write = grant ? bus.req1_write : bus.req0_write;
  assign sel_addr  = grant ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = grant ? bus.req1_wdata : bus.req0_wdata;

  assign bus.req0_ready = (state_q == S_IDLE) & any_req & ~grant;
  assign bus.req1_ready = (state_q == S_IDLE) & any_req & grant;

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      id_q         <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          last_grant_d = grant;
          id_d         = grant;
          pwrite_d     = sel_write;
          paddr_d      = sel_addr;
          pwdata_d     = sel_wdata;
          if (sel_addr < ADDR_LIM) begin
            // APB outputs are registered, so psel is raised on the accept edge.
            state_d = S_SETUP;
            psel_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        if (bus.pready) begin
          state_d     = S_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_err_d   = bus.pslverr;
          rsp_rdata_d = (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
        end else if (cnt_q == TO_LAST) begin
          state_d     = S_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_err_d   = 1'b1;
        end
      end
      S_ERR: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: registered-pready slave model with hang and
// error knobs, linear stimulus with immediate-assertion checks.
module tb_apb_rr_master;

  logic       pclk;
  logic       prst_n;
  logic [1:0] dbg_state;
  logic       hang;
  logic       err_mode;
  logic [31:0] mem [16];

  int n_cmp = 0;
  int n_err = 0;

  apb_rr_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_rr_master #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(10), .TIMEOUT(16)) dut (
    .pclk        (pclk),
    .prst_n      (prst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // slave model: pready registered from psel&penable, so it lingers one cycle
  always @(posedge pclk or negedge prst_n) begin
    if (!prst_n) bus.pready <= 1'b0;
    else         bus.pready <= bus.psel & bus.penable & ~hang;
  end
  assign bus.pslverr = err_mode & bus.psel & bus.penable;
  assign bus.prdata  = mem[bus.paddr[3:0]];
  always @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (bus.psel && bus.penable && bus.pready && bus.pwrite && !bus.pslverr) begin
      mem[bus.paddr[3:0]] <= bus.pwdata;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit id, input bit v, input bit wr, input logic [31:0] a,
                       input logic [31:0] d);
    if (id) begin
      bus.req1_valid = v; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
    end else begin
      bus.req0_valid = v; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
    end
  endtask

  // Issue one command; report response and timing (lat counted from accept cycle).
  task automatic do_cmd(input bit id, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output logic rid,
                        output int lat, output int acc, output bit psel_seen);
    bit ok;
    ok = 1'b0; rd = '0; er = 1'b0; rid = 1'b0; lat = 0; acc = 0; psel_seen = 1'b0;
    drive(id, 1'b1, wr, a, d);
    #1;
    for (int c = 0; c < 20; c++) begin
      if (id ? bus.req1_ready : bus.req0_ready) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) chk("accept_bound", 32'd0, 32'd1);
    tick();
    drive(id, 1'b0, 1'b0, 32'h0, 32'h0);
    lat = 1;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (bus.rsp_valid) begin ok = 1'b1; break; end
      if (bus.psel && bus.penable) acc++;
      if (bus.psel) psel_seen = 1'b1;
      tick();
      lat++;
    end
    if (!ok) chk("rsp_bound", 32'd0, 32'd1);
    rd = bus.rsp_rdata; er = bus.rsp_err; rid = bus.rsp_id;
  endtask

  // scoreboard for round-robin response ordering
  logic [0:0] exp_q[$];

  initial begin
    logic [31:0] rd;
    logic        er, rid;
    int          lat, acc, n_rsp, g0, g1;
    bit          ps, exp_grant, gid;

    hang = 1'b0; err_mode = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    prst_n = 1'b0;
    repeat (3) tick();
    @(negedge pclk) prst_n = 1'b1;
    tick();

    // reset state
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_pwrite", bus.pwrite, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_ready0_idle", bus.req0_ready, 0);

    // round-robin: both held valid, four writes each
    g0 = 0; g1 = 0; n_rsp = 0; exp_grant = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 32'd0, 32'h100);
    drive(1'b1, 1'b1, 1'b1, 32'd4, 32'h200);
    #1;
    for (int c = 0; c < 300 && n_rsp < 8; c++) begin
      if (bus.rsp_valid) begin
        if (exp_q.size() > 0) chk("rr_rsp_id", bus.rsp_id, exp_q.pop_front());
        else chk("rr_rsp_unexpected", 32'd1, 32'd0);
        n_rsp++;
      end
      if (bus.req0_ready || bus.req1_ready) begin
        chk("rr_one_hot", bus.req0_ready & bus.req1_ready, 0);
        gid = bus.req1_ready;
        chk("rr_grant", gid, exp_grant);
        exp_q.push_back(gid);
        exp_grant = ~exp_grant;
        tick();
        if (gid) begin
          g1++;
          drive(1'b1, g1 < 4, 1'b1, 32'(4 + g1), 32'h200 + 32'(g1));
        end else begin
          g0++;
          drive(1'b0, g0 < 4, 1'b1, 32'(g0), 32'h100 + 32'(g0));
        end
      end else begin
        tick();
      end
    end
    chk("rr_rsp_count", n_rsp, 8);
    chk("rr_mem_req1_last", mem[7], 32'h203);

    // single write with cycle-accurate phase checks, then back-to-back read
    drive(1'b0, 1'b1, 1'b1, 32'd3, 32'hDEAD_BEEF);
    #1;
    chk("wr_ready0", bus.req0_ready, 1);
    chk("wr_ready1", bus.req1_ready, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wr_setup_psel", bus.psel, 1);
    chk("wr_setup_penable", bus.penable, 0);
    chk("wr_setup_paddr", bus.paddr, 3);
    chk("wr_setup_pwrite", bus.pwrite, 1);
    chk("wr_setup_pwdata", bus.pwdata, 32'hDEAD_BEEF);
    tick();
    chk("wr_acc1_penable", bus.penable, 1);
    chk("wr_acc1_rsp_valid", bus.rsp_valid, 0);
    tick();
    chk("wr_acc2_psel", bus.psel, 1);
    chk("wr_acc2_penable", bus.penable, 1);
    tick();
    chk("wr_rsp_valid", bus.rsp_valid, 1);
    chk("wr_rsp_id", bus.rsp_id, 0);
    chk("wr_rsp_err", bus.rsp_err, 0);
    chk("wr_rsp_rdata", bus.rsp_rdata, 0);
    chk("wr_rsp_psel", bus.psel, 0);
    drive(1'b0, 1'b1, 1'b0, 32'd3, 32'h0);
    #1;
    chk("b2b_ready0", bus.req0_ready, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("b2b_setup_pwrite", bus.pwrite, 0);
    tick();
    chk("b2b_acc_rsp_valid", bus.rsp_valid, 0);
    tick();
    tick();
    chk("rd_rsp_valid", bus.rsp_valid, 1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_err", bus.rsp_err, 0);
    tick();
    chk("rd_rsp_pulse", bus.rsp_valid, 0);

    // address guard: addr == MEM_DEPTH rejected, MEM_DEPTH-1 accepted
    do_cmd(1'b1, 1'b0, 32'd10, 32'h0, rd, er, rid, lat, acc, ps);
    chk("guard_lat", lat, 2);
    chk("guard_psel_seen", ps, 0);
    chk("guard_err", er, 1);
    chk("guard_id", rid, 1);
    chk("guard_rdata", rd, 0);
    do_cmd(1'b1, 1'b1, 32'd9, 32'h1234_5678, rd, er, rid, lat, acc, ps);
    chk("edge9_err", er, 0);
    chk("edge9_lat", lat, 4);
    chk("edge9_acc", acc, 2);
    chk("edge9_mem", mem[9], 32'h1234_5678);

    // timeout with hung slave, then a normal command
    hang = 1'b1;
    do_cmd(1'b0, 1'b0, 32'd3, 32'h0, rd, er, rid, lat, acc, ps);
    chk("to_acc_cycles", acc, 16);
    chk("to_lat", lat, 18);
    chk("to_err", er, 1);
    chk("to_rdata", rd, 0);
    chk("to_psel", bus.psel, 0);
    chk("to_penable", bus.penable, 0);
    hang = 1'b0;
    do_cmd(1'b1, 1'b0, 32'd9, 32'h0, rd, er, rid, lat, acc, ps);
    chk("post_to_rdata", rd, 32'h1234_5678);
    chk("post_to_err", er, 0);
    chk("post_to_id", rid, 1);

    // slave error on a read
    err_mode = 1'b1;
    do_cmd(1'b0, 1'b0, 32'd3, 32'h0, rd, er, rid, lat, acc, ps);
    chk("slverr_err", er, 1);
    chk("slverr_rdata", rd, 0);
    chk("slverr_lat", lat, 4);
    err_mode = 1'b0;

    // reset during ACCESS; last grant was req0, reset must restore req0 priority
    drive(1'b0, 1'b1, 1'b1, 32'd4, 32'hCAFE_0004);
    #1;
    chk("rstmid_ready0", bus.req0_ready, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("rstmid_in_access", bus.penable, 1);
    #2 prst_n = 1'b0;
    #1;
    chk("rstmid_psel", bus.psel, 0);
    chk("rstmid_penable", bus.penable, 0);
    chk("rstmid_rsp_valid", bus.rsp_valid, 0);
    chk("rstmid_state", dbg_state, 0);
    tick();
    tick();
    @(negedge pclk) prst_n = 1'b1;
    tick();
    chk("rstmid_no_rsp", bus.rsp_valid, 0);
    drive(1'b0, 1'b1, 1'b1, 32'd2, 32'h22);
    drive(1'b1, 1'b1, 1'b1, 32'd5, 32'h55);
    #1;
    chk("rstmid_grant0", bus.req0_ready, 1);
    chk("rstmid_grant1", bus.req1_ready, 0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    tick();
    chk("rstmid_rsp_valid_after", bus.rsp_valid, 1);
    chk("rstmid_rsp_id_after", bus.rsp_id, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Two-port round-robin APB master that shares the single-slave register/memory APB target between two internal requesters.
- Accepts one command at a time from a winning requester and sequences the APB SETUP/ACCESS phases.
- Returns one response per accepted command, tagged with the requester ID.
- Adds an address range guard and a pready timeout so a bad address or a hung slave cannot stall the system.

Parameters:
- ADDR_W, 32, width of paddr and requester addresses.
- DATA_W, 32, width of pwdata/prdata and requester data.
- MEM_DEPTH, 10, number of valid slave words; addr >= MEM_DEPTH is rejected locally.
- TIMEOUT, 16, maximum ACCESS cycles to wait for pready; legal range 2..255.

Ports:
- pclk  in  1  clock; all state updates on rising edge.
- prst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  command request from requester 0 / 1.
- req0_ready / req1_ready  out  1  command accepted this cycle; combinational, IDLE only.
- req0_write / req1_write  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  ADDR_W  word address.
- req0_wdata / req1_wdata  in  DATA_W  write data.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  requester that owns the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  pslverr, timeout, or address-range error.

Behaviour:
- Reset (async assert, sync release):
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_id, rsp_rdata, rsp_err all 0.
  - State IDLE; last_grant = 1, so requester 0 wins first; timeout counter 0.
  - Reset mid-transfer drops psel/penable immediately and discards the command; no response is issued.
- States: IDLE, SETUP, ACCESS, ERR.
- IDLE:
  - Winner selection: if both valid, the requester != last_grant wins; otherwise the sole valid requester wins.
  - reqN_ready = 1 for the winner only, same cycle. Command (write, addr, wdata, id) is latched and last_grant updates.
  - Next state is SETUP if addr < MEM_DEPTH, else ERR.
  - No valid request: stay IDLE, both ready = 0.
- SETUP (one cycle): psel=1, penable=0, paddr/pwrite/pwdata from the latched command; -> ACCESS.
- ACCESS:
  - psel=1, penable=1, address/data held stable; counter increments each ACCESS cycle.
  - pready=1: -> IDLE and next cycle rsp_valid=1, rsp_err=pslverr, rsp_rdata=prdata if read and !pslverr (else 0).
  - Counter reaching TIMEOUT with pready=0: -> IDLE, psel/penable drop, rsp_valid=1, rsp_err=1, rsp_rdata=0.
- ERR (one cycle): no APB activity; -> IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=0, rsp_id of the rejected requester.
- Outputs: psel/penable/paddr/pwrite/pwdata are registered; psel=penable=0 in IDLE and ERR.
- rsp_valid: asserted exactly one cycle per accepted command.
- Counter: clears on entry to SETUP.
- Latency against a registered-pready slave:
  - Accept cycle 0, SETUP cycle 1, ACCESS cycles 2-3, rsp_valid cycle 4.
  - IDLE in cycle 4 may accept the next command (back-to-back).
  - The stale pready=1 in cycle 4 is ignored because the FSM is not in ACCESS.
- Requesters must hold valid and payload until ready; valid dropped before ready is permitted and is not a command.

Test Plan:
- Single write then read: req0 write addr 3, wdata 32'hDEAD_BEEF; then req0 read addr 3 -> APB write with SETUP+2 ACCESS cycles; rsp_valid cycle 4 with rsp_id=0, rsp_err=0; read response rsp_rdata=32'hDEAD_BEEF.
- Round-robin: req0 and req1 both held valid with four commands each -> grants alternate 0,1,0,1,...; first grant is requester 0; every rsp_id matches the grant order.
- Address guard: req1 read addr 10 -> psel never asserts; rsp_valid 2 cycles after accept with rsp_err=1, rsp_id=1, rsp_rdata=0.
- Timeout: slave model holds pready=0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then psel=0 and rsp_err=1; the next command proceeds normally.
- Slave error: pslverr=1 with pready=1 on a read -> rsp_err=1, rsp_rdata=0.
- Reset mid-ACCESS: prst_n low during ACCESS -> psel, penable and rsp_valid are 0 immediately; after release, req0 is granted first when both requesters are valid.
